clock_edge_monitor: RTL

Fast-domain monitor for the divided processor clock produced by the clock manager, or for any slow external clock. Synchronizes the slow clock into `clk`, emits single-cycle rising/falling-edge enables, measures the slow-clock period in `clk` cycles, and flags loss of clock. Downstream logic runs on `clk` and uses `rise_pulse` as a clock enable instead of clocking directly from the slow clock.

---
 rtl/clock_edge_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clock_edge_monitor.sv
// Slow-clock monitor: synchronizes clk_in into clk and emits one-cycle edge enables.
// Also measures the clk_in period and flags loss of clock. Period measurement is built only with PERIOD_MEASURE_EN.
module clock_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 60000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             clk_sync,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             clk_lost,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        LOST = 2'd3
    } state_t;

    localparam logic [2:0]       PRIME_DONE = 3'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [2:0]             prime_cnt;
    logic                   primed;
    logic [CNT_W-1:0]       cnt;
    logic                   timeout_hit;
    state_t                 state;

    assign clk_sync    = sync_q[SYNC_STAGES-1];
    assign primed      = (prime_cnt == PRIME_DONE);
    assign timeout_hit = (cnt == TIMEOUT_V);
    assign dbg_state   = state;

    // Edge detection stays masked until the synchronizer and prev have both
    // settled, so whatever static level was present at reset gives no pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            prev       <= 1'b0;
            prime_cnt  <= 3'd0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            cnt        <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev       <= clk_sync;
            if (!primed) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
            rise_pulse <= primed & clk_sync & ~prev;
            fall_pulse <= primed & ~clk_sync & prev;
            if (rise_pulse) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A rise_pulse always wins over a simultaneous timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            clk_lost <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_pulse) begin
                        state <= ARM;
                    end else if (timeout_hit) begin
                        state    <= LOST;
                        clk_lost <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise_pulse) begin
                        state <= RUN;
                    end else if (timeout_hit) begin
                        state    <= LOST;
                        clk_lost <= 1'b1;
                    end
                end
                RUN: begin
                    if (!rise_pulse && timeout_hit) begin
                        state    <= LOST;
                        clk_lost <= 1'b1;
                    end
                end
                LOST: begin
                    if (rise_pulse) begin
                        state    <= ARM;
                        clk_lost <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clk_lost <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERIOD_MEASURE_EN
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;

    // period holds its last measurement across loss; only period_valid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            if (rise_pulse && (state == ARM || state == RUN)) begin
                period_q       <= cnt;
                period_valid_q <= 1'b1;
            end else if (!rise_pulse && timeout_hit && state == RUN) begin
                period_valid_q <= 1'b0;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule
